// File: rtl/universal_shift_reg_multi.sv
// Parametrised universal shift register with single-step operations and a
// start/busy/done multi-cycle shift-by-N engine.
module universal_shift_reg_multi #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] prl_in,
  input  logic             srl_in_r,
  input  logic             srl_in_l,
  input  logic             start,
  input  logic [CW-1:0]    amt,
  output logic [WIDTH-1:0] out,
  output logic             srl_out_l,
  output logic             srl_out_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [2:0]       r_op;
  logic [2:0]       w_op_nxt;
  logic [CW-1:0]    w_amt_clamp;

  function automatic logic [WIDTH-1:0] step_f(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] pl,
    input logic             sr,
    input logic             sl
  );
    logic [WIDTH-1:0] res;
    case (op)
      3'b001:  res = {cur[WIDTH-2:0], sr};
      3'b010:  res = {sl, cur[WIDTH-1:1]};
      3'b011:  res = pl;
      3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  res = {cur[0], cur[WIDTH-1:1]};
      3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: res = cur;
    endcase
    return res;
  endfunction

  // Only shift/rotate ops take the multi-cycle path; hold and LOAD finish at once.
  function automatic logic is_shift_f(input logic [2:0] op);
    logic res;
    case (op)
      3'b001, 3'b010, 3'b100, 3'b101, 3'b110: res = 1'b1;
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

  assign w_amt_clamp = (amt > CW'(WIDTH)) ? CW'(WIDTH) : amt;

  // Next-state, datapath and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_op_nxt  = mode;
          w_cnt_nxt = w_amt_clamp;
          if ((w_amt_clamp != '0) && is_shift_f(mode)) begin
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else if (en) begin
          w_out_nxt = step_f(mode, r_out, prl_in, srl_in_r, srl_in_l);
        end else begin
          w_out_nxt = r_out;
        end
      end
      S_SHIFT: begin
        w_out_nxt = step_f(r_op, r_out, prl_in, srl_in_r, srl_in_l);
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_cnt   <= '0;
      r_op    <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  assign out       = r_out;
  assign srl_out_l = r_out[WIDTH-1];
  assign srl_out_r = r_out[0];
  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_universal_shift_reg_multi.sv
// Directed self-checking bench for universal_shift_reg_multi at WIDTH=8.
module tb_universal_shift_reg_multi;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] prl_in;
  logic       srl_in_r;
  logic       srl_in_l;
  logic       start;
  logic [3:0] amt;
  logic [7:0] out;
  logic       srl_out_l;
  logic       srl_out_r;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  universal_shift_reg_multi #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .prl_in(prl_in),
    .srl_in_r(srl_in_r), .srl_in_l(srl_in_l), .start(start), .amt(amt),
    .out(out), .srl_out_l(srl_out_l), .srl_out_r(srl_out_r),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample out/busy/done together.
  task automatic chk3(input string tag, input logic [7:0] e_out, input logic e_busy, input logic e_done);
    chk({tag, "_out"},  out,         e_out);
    chk({tag, "_busy"}, {7'd0, busy}, {7'd0, e_busy});
    chk({tag, "_done"}, {7'd0, done}, {7'd0, e_done});
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 3'b000; prl_in = 8'h00;
    srl_in_r = 1'b0; srl_in_l = 1'b0; start = 1'b0; amt = 4'd0;
    tick();
    tick();
    chk3("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk3("post_reset_hold", 8'h00, 1'b0, 1'b0);

    // Single-step LOAD / ROL / ROR and serial outputs
    en = 1'b1; mode = 3'b011; prl_in = 8'hAA;
    tick();
    chk("load_aa", out, 8'hAA);
    chk("srl_out_l_aa", {7'd0, srl_out_l}, 8'h01);
    chk("srl_out_r_aa", {7'd0, srl_out_r}, 8'h00);
    mode = 3'b100;
    tick();
    chk("rol_step", out, 8'h55);
    mode = 3'b101;
    tick();
    chk("ror_step", out, 8'hAA);

    // SHL / SHR with serial inputs
    mode = 3'b011; prl_in = 8'h81;
    tick();
    chk("load_81", out, 8'h81);
    mode = 3'b001; srl_in_r = 1'b1;
    tick();
    chk("shl_1", out, 8'h03);
    tick();
    chk("shl_2", out, 8'h07);
    mode = 3'b010; srl_in_l = 1'b0;
    tick();
    chk("shr_1", out, 8'h03);
    mode = 3'b010; srl_in_l = 1'b1;
    tick();
    chk("shr_in1", out, 8'h81);
    mode = 3'b110;
    tick();
    chk("asr_step", out, 8'hC0);
    mode = 3'b111;
    tick();
    chk("hold_111", out, 8'hC0);
    en = 1'b0; mode = 3'b001;
    tick();
    chk("en_low_hold", out, 8'hC0);

    // Multi-cycle ASR by 3
    en = 1'b1; mode = 3'b011; prl_in = 8'h96;
    tick();
    chk("load_96", out, 8'h96);
    en = 1'b0; start = 1'b1; mode = 3'b110; amt = 4'd3;
    tick();
    chk3("asr_latch", 8'h96, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    tick();
    chk3("asr_s1", 8'hCB, 1'b1, 1'b0);
    tick();
    chk3("asr_s2", 8'hE5, 1'b1, 1'b0);
    tick();
    chk3("asr_s3", 8'hF2, 1'b0, 1'b1);
    tick();
    chk3("asr_after", 8'hF2, 1'b0, 1'b0);

    // ROL amt=12 clamps to 8; start/en/mode during busy ignored
    en = 1'b1; mode = 3'b011; prl_in = 8'h5A;
    tick();
    chk("load_5a", out, 8'h5A);
    en = 1'b0; start = 1'b1; mode = 3'b100; amt = 4'd12;
    tick();
    chk3("rol_latch", 8'h5A, 1'b1, 1'b0);
    en = 1'b1; mode = 3'b011; prl_in = 8'h00; amt = 4'd1;
    tick();
    chk3("rol_s1", 8'hB4, 1'b1, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      tick();
      chk("rol_busy_mid", {7'd0, busy}, 8'h01);
    end
    chk("rol_s7", out, 8'h2D);
    start = 1'b0; en = 1'b0; mode = 3'b000;
    tick();
    chk3("rol_s8", 8'h5A, 1'b0, 1'b1);
    tick();
    chk3("rol_after", 8'h5A, 1'b0, 1'b0);

    // amt=0 and LOAD via start go straight to DONE
    start = 1'b1; mode = 3'b001; amt = 4'd0;
    tick();
    chk3("amt0", 8'h5A, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    chk3("amt0_after", 8'h5A, 1'b0, 1'b0);
    start = 1'b1; mode = 3'b011; amt = 4'd3; prl_in = 8'hFF;
    tick();
    chk3("start_load", 8'h5A, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    chk3("start_load_after", 8'h5A, 1'b0, 1'b0);

    // Reset mid-run aborts with no done pulse
    en = 1'b1; mode = 3'b011; prl_in = 8'h01;
    tick();
    en = 1'b0; start = 1'b1; mode = 3'b101; amt = 4'd5;
    tick();
    start = 1'b0;
    tick();
    chk3("ror_s1", 8'h80, 1'b1, 1'b0);
    tick();
    chk3("ror_s2", 8'h40, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk3("async_reset", 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk3("reset_release", 8'h00, 1'b0, 1'b0);
    tick();
    chk3("reset_no_done", 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
